// File: rtl/hilo_muldiv_unit.sv
// hilo_muldiv_unit
// Multi-cycle multiply/divide engine with the MIPS HI/LO register pair.
// Executes MULT, MULTU, DIV, DIVU (iterative, 33-cycle latency), plus
// MTHI/MTLO and divide-by-zero (written at the accept edge).
// Optional build macro: HILO_FAST_MULT_EN -- when defined, MULT/MULTU use a
// single-cycle 32x32 multiply with MTHI-style timing; division is unchanged.
module hilo_muldiv_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [4:0]  alu_control,
    input  logic        LO_write_enable,
    input  logic        HI_write_enable,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [4:0] OP_MULT  = 5'b10000;
    localparam logic [4:0] OP_MULTU = 5'b10001;
    localparam logic [4:0] OP_DIV   = 5'b10010;
    localparam logic [4:0] OP_DIVU  = 5'b10011;
    localparam logic [4:0] OP_MTLO  = 5'b10101;
    localparam logic [4:0] OP_MTHI  = 5'b10110;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_FIX,
        S_DONE
    } state_t;

    state_t      state_reg;
    logic [4:0]  count_reg;
    logic        busy_reg;
    logic        done_reg;
    logic [31:0] hi_reg;
    logic [31:0] lo_reg;
    // Shared working pair: {product_hi, multiplier/product_lo} for MUL,
    // {remainder, dividend/quotient} for DIV.
    logic [31:0] work_hi_reg;
    logic [31:0] work_lo_reg;
    // Multiplicand magnitude (MUL) or divisor magnitude (DIV).
    logic [31:0] opnd_reg;
    logic        sign_a_reg;
    logic        sign_b_reg;
    logic        is_div_reg;

    // Instruction decode and accept qualification.
    logic        is_mul_code;
    logic        is_div_code;
    logic        is_signed_code;
    logic        legal;
    logic        accept;
    logic        sign_a;
    logic        sign_b;
    logic [31:0] mag_a;
    logic [31:0] mag_b;

    assign is_mul_code    = (alu_control == OP_MULT) || (alu_control == OP_MULTU);
    assign is_div_code    = (alu_control == OP_DIV)  || (alu_control == OP_DIVU);
    assign is_signed_code = (alu_control == OP_MULT) || (alu_control == OP_DIV);
    assign legal  = ((is_mul_code || is_div_code) && HI_write_enable && LO_write_enable)
                 || ((alu_control == OP_MTHI) && HI_write_enable)
                 || ((alu_control == OP_MTLO) && LO_write_enable);
    assign accept = start && !busy_reg && legal;

    // Signs are only meaningful for signed ops; unsigned ops keep raw values.
    assign sign_a = is_signed_code & op_a[31];
    assign sign_b = is_signed_code & op_b[31];
    assign mag_a  = sign_a ? (32'd0 - op_a) : op_a;
    assign mag_b  = sign_b ? (32'd0 - op_b) : op_b;

    // One shift-add multiply step: conditionally add multiplicand, shift right.
    logic [32:0] mul_sum;
    logic [63:0] mul_next;
    assign mul_sum  = {1'b0, work_hi_reg} + (work_lo_reg[0] ? {1'b0, opnd_reg} : 33'd0);
    assign mul_next = {mul_sum, work_lo_reg[31:1]};

    // One restoring-division step: shift in next dividend bit, trial subtract.
    logic [32:0] div_shift;
    logic        div_ge;
    logic [31:0] rem_next;
    logic [31:0] q_next;
    assign div_shift = {work_hi_reg, work_lo_reg[31]};
    assign div_ge    = div_shift >= {1'b0, opnd_reg};
    assign rem_next  = div_ge ? (div_shift[31:0] - opnd_reg) : div_shift[31:0];
    assign q_next    = {work_lo_reg[30:0], div_ge};

`ifdef HILO_FAST_MULT_EN
    // Single-cycle product; extending per signedness makes the low 64 bits
    // of an unsigned 64x64 multiply correct for both MULT and MULTU.
    logic [63:0] fast_a;
    logic [63:0] fast_b;
    logic [63:0] fast_prod;
    assign fast_a    = is_signed_code ? {{32{op_a[31]}}, op_a} : {32'd0, op_a};
    assign fast_b    = is_signed_code ? {{32{op_b[31]}}, op_b} : {32'd0, op_b};
    assign fast_prod = fast_a * fast_b;
`endif

    // Sign correction applied in FIX before the HI/LO write.
    logic [31:0] fix_hi;
    logic [31:0] fix_lo;
    logic [63:0] prod;
    always_comb begin
        prod   = {work_hi_reg, work_lo_reg};
        fix_hi = work_hi_reg;
        fix_lo = work_lo_reg;
        if (is_div_reg) begin
            fix_lo = (sign_a_reg ^ sign_b_reg) ? (32'd0 - work_lo_reg) : work_lo_reg;
            fix_hi = sign_a_reg ? (32'd0 - work_hi_reg) : work_hi_reg;
        end else if (sign_a_reg ^ sign_b_reg) begin
            {fix_hi, fix_lo} = 64'd0 - prod;
        end
    end

    // Control FSM, iteration datapath and HI/LO registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= S_IDLE;
            count_reg   <= 5'd0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
            hi_reg      <= 32'd0;
            lo_reg      <= 32'd0;
            work_hi_reg <= 32'd0;
            work_lo_reg <= 32'd0;
            opnd_reg    <= 32'd0;
            sign_a_reg  <= 1'b0;
            sign_b_reg  <= 1'b0;
            is_div_reg  <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                S_IDLE, S_DONE: begin
                    state_reg <= S_IDLE;
                    if (accept) begin
                        if (alu_control == OP_MTHI) begin
                            hi_reg    <= op_a;
                            done_reg  <= 1'b1;
                            state_reg <= S_DONE;
                        end else if (alu_control == OP_MTLO) begin
                            lo_reg    <= op_a;
                            done_reg  <= 1'b1;
                            state_reg <= S_DONE;
                        end else if (is_div_code && (op_b == 32'd0)) begin
                            hi_reg    <= op_a;
                            lo_reg    <= 32'hFFFF_FFFF;
                            done_reg  <= 1'b1;
                            state_reg <= S_DONE;
                        end else if (is_div_code) begin
                            work_hi_reg <= 32'd0;
                            work_lo_reg <= mag_a;
                            opnd_reg    <= mag_b;
                            sign_a_reg  <= sign_a;
                            sign_b_reg  <= sign_b;
                            is_div_reg  <= 1'b1;
                            count_reg   <= 5'd0;
                            busy_reg    <= 1'b1;
                            state_reg   <= S_DIV;
                        end else begin
`ifdef HILO_FAST_MULT_EN
                            hi_reg    <= fast_prod[63:32];
                            lo_reg    <= fast_prod[31:0];
                            done_reg  <= 1'b1;
                            state_reg <= S_DONE;
`else
                            work_hi_reg <= 32'd0;
                            work_lo_reg <= mag_b;
                            opnd_reg    <= mag_a;
                            sign_a_reg  <= sign_a;
                            sign_b_reg  <= sign_b;
                            is_div_reg  <= 1'b0;
                            count_reg   <= 5'd0;
                            busy_reg    <= 1'b1;
                            state_reg   <= S_MUL;
`endif
                        end
                    end
                end
                S_MUL: begin
                    work_hi_reg <= mul_next[63:32];
                    work_lo_reg <= mul_next[31:0];
                    count_reg   <= count_reg + 5'd1;
                    if (count_reg == 5'd31) begin
                        state_reg <= S_FIX;
                    end
                end
                S_DIV: begin
                    work_hi_reg <= rem_next;
                    work_lo_reg <= q_next;
                    count_reg   <= count_reg + 5'd1;
                    if (count_reg == 5'd31) begin
                        state_reg <= S_FIX;
                    end
                end
                S_FIX: begin
                    hi_reg    <= fix_hi;
                    lo_reg    <= fix_lo;
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b1;
                    state_reg <= S_DONE;
                end
                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

    assign busy = busy_reg;
    assign done = done_reg;
    assign hi   = hi_reg;
    assign lo   = lo_reg;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Scoreboard bench for hilo_muldiv_unit: stimulus pushes expected HI/LO and
// done-edge into a queue; a monitor pops and compares on every done pulse.
module tb_hilo_muldiv_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [4:0]  alu_control = 5'd0;
    logic        LO_write_enable = 1'b0;
    logic        HI_write_enable = 1'b0;
    logic [31:0] op_a = 32'd0;
    logic [31:0] op_b = 32'd0;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    hilo_muldiv_unit dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .alu_control     (alu_control),
        .LO_write_enable (LO_write_enable),
        .HI_write_enable (HI_write_enable),
        .op_a            (op_a),
        .op_b            (op_b),
        .busy            (busy),
        .done            (done),
        .hi              (hi),
        .lo              (lo)
    );

    always #5 clk = ~clk;

`ifdef HILO_FAST_MULT_EN
    localparam bit FAST_MUL = 1'b1;
`else
    localparam bit FAST_MUL = 1'b0;
`endif

    localparam logic [4:0] C_MULT  = 5'b10000;
    localparam logic [4:0] C_MULTU = 5'b10001;
    localparam logic [4:0] C_DIV   = 5'b10010;
    localparam logic [4:0] C_DIVU  = 5'b10011;
    localparam logic [4:0] C_MTLO  = 5'b10101;
    localparam logic [4:0] C_MTHI  = 5'b10110;

    typedef struct {
        logic [31:0] h;
        logic [31:0] l;
        int          edge_n;
    } exp_t;

    exp_t        exp_q[$];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    logic [31:0] mh = 32'd0;
    logic [31:0] ml = 32'd0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Architectural reference: plain 64-bit arithmetic on the MIPS semantics.
    function automatic void model(input logic [4:0] c, input logic hwe, input logic lwe,
                                  input logic [31:0] a, input logic [31:0] b,
                                  input logic [31:0] ch, input logic [31:0] cl,
                                  output bit legal, output bit iter,
                                  output logic [31:0] nh, output logic [31:0] nl);
        longint      sa;
        longint      sb;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        nh = ch;
        nl = cl;
        legal = 1'b0;
        iter = 1'b0;
        case (c)
            C_MULT: if (hwe && lwe) begin
                legal = 1'b1; iter = !FAST_MUL;
                p = 64'(sa * sb); nh = p[63:32]; nl = p[31:0];
            end
            C_MULTU: if (hwe && lwe) begin
                legal = 1'b1; iter = !FAST_MUL;
                p = {32'd0, a} * {32'd0, b}; nh = p[63:32]; nl = p[31:0];
            end
            C_DIV: if (hwe && lwe) begin
                legal = 1'b1;
                if (b == 32'd0) begin nh = a; nl = 32'hFFFF_FFFF; end
                else begin iter = 1'b1; nl = 32'(sa / sb); nh = 32'(sa % sb); end
            end
            C_DIVU: if (hwe && lwe) begin
                legal = 1'b1;
                if (b == 32'd0) begin nh = a; nl = 32'hFFFF_FFFF; end
                else begin iter = 1'b1; nl = a / b; nh = a % b; end
            end
            C_MTLO: if (lwe) begin legal = 1'b1; nl = a; end
            C_MTHI: if (hwe) begin legal = 1'b1; nh = a; end
            default: ;
        endcase
    endfunction

    // Drive one start pulse (called just after a falling edge) and record expectation.
    task automatic issue(input logic [4:0] c, input logic hwe, input logic lwe,
                         input logic [31:0] a, input logic [31:0] b, output bit legal);
        bit          iter;
        logic [31:0] nh;
        logic [31:0] nl;
        model(c, hwe, lwe, a, b, mh, ml, legal, iter, nh, nl);
        alu_control = c; HI_write_enable = hwe; LO_write_enable = lwe;
        op_a = a; op_b = b; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        if (legal) begin
            mh = nh; ml = nl;
            exp_q.push_back('{h: nh, l: nl, edge_n: cyc + (iter ? 33 : 0)});
        end
        $display("op code=%b hwe=%0d lwe=%0d a=%h b=%h legal=%0d iter=%0d", c, hwe, lwe, a, b, legal, iter);
        chk("busy_after_accept", {31'd0, busy}, {31'd0, iter});
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 80 && exp_q.size() != 0; i++) begin
            @(negedge clk);
            #2;
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL done_timeout: pending=%0d expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic check_hold();
        repeat (3) @(negedge clk);
        #2;
        chk("hold_hi", hi, mh);
        chk("hold_lo", lo, ml);
    endtask

    function automatic logic [31:0] rnd_val();
        case ($urandom_range(0, 6))
            0: return 32'd0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    // Monitor: every done pulse must match the oldest expectation, at its edge.
    always @(negedge clk) begin
        if (!reset && done) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: got done=1 expected none pending");
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("hi", hi, e.h);
                chk("lo", lo, e.l);
                chk("done_edge", 32'(cyc), 32'(e.edge_n));
                $display("done hi=%h lo=%h cycle=%0d", hi, lo, cyc);
            end
        end
    end

    logic [4:0] codes [7] = '{C_MULT, C_MULTU, C_DIV, C_DIVU, C_MTLO, C_MTHI, 5'b10100};

    initial begin
        bit legal;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        #2;
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_done", {31'd0, done}, 32'd0);
        chk("reset_hi", hi, 32'd0);
        chk("reset_lo", lo, 32'd0);

        // Directed cases.
        issue(C_MULT,  1, 1, 32'hFFFF_FFFD, 32'd7, legal);        wait_idle();
        issue(C_MULTU, 1, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, legal); wait_idle();
        issue(C_DIV,   1, 1, 32'hFFFF_FFF9, 32'd2, legal);        wait_idle();
        issue(C_DIVU,  1, 1, 32'd7, 32'd2, legal);                wait_idle();
        issue(C_DIV,   1, 1, 32'h8000_0000, 32'hFFFF_FFFF, legal); wait_idle();
        issue(C_DIVU,  1, 1, 32'h1234, 32'd0, legal);             wait_idle();

        // MTLO while busy is dropped.
        issue(C_DIV, 1, 1, 32'd1000, 32'd7, legal);
        repeat (5) @(negedge clk);
        alu_control = C_MTLO; LO_write_enable = 1'b1; HI_write_enable = 1'b0;
        op_a = 32'hAAAA; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        chk("busy_during_ignored", {31'd0, busy}, 32'd1);
        wait_idle();
        issue(C_MTHI, 1, 0, 32'h55, 32'd0, legal); wait_idle();

        // Illegal enable/code combinations are no-ops.
        issue(C_MTHI, 0, 1, 32'h77, 32'd0, legal); check_hold();
        issue(C_MULT, 1, 0, 32'd3, 32'd3, legal);  check_hold();
        issue(5'b10100, 1, 1, 32'd9, 32'd9, legal); check_hold();

        // Randomized mix.
        for (int n = 0; n < 40; n++) begin
            logic [4:0]  c;
            logic        hwe;
            logic        lwe;
            c = codes[$urandom_range(0, 6)];
            hwe = ($urandom_range(0, 9) != 0);
            lwe = ($urandom_range(0, 9) != 0);
            issue(c, hwe, lwe, rnd_val(), rnd_val(), legal);
            if (legal) wait_idle();
            else check_hold();
        end

        // Reset at cycle 10 of a DIV aborts it.
        issue(C_DIV, 1, 1, 32'd12345, 32'd3, legal);
        repeat (9) @(negedge clk);
        reset = 1'b1;
        exp_q.delete();
        mh = 32'd0; ml = 32'd0;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        #2;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        chk("abort_hi", hi, 32'd0);
        chk("abort_lo", lo, 32'd0);
        repeat (40) @(negedge clk);
        #2;
        chk("abort_busy_later", {31'd0, busy}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
